// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the byte-lane helper used by the sub-word store merge.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Byte-lane enables for each access width, before shifting to the offset.
  localparam logic [3:0] LANES_B = 4'b0001;
  localparam logic [3:0] LANES_H = 4'b0011;
  localparam logic [3:0] LANES_W = 4'b1111;

  // Lanes touched by an access; halfwords are placed by addr[1] only.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                           input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return LANES_B << off;
      2'b01:   return LANES_H << {off[1], 1'b0};
      default: return LANES_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and memory-side signals of the load/store unit.
// master: core datapath plus data memory; slave: the LSU itself.
interface lsu_mem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;
  logic [XLEN-1:0] mem_A;
  logic [XLEN-1:0] mem_WD;
  logic            mem_WE;
  logic [XLEN-1:0] mem_RD;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_A, mem_WD, mem_WE
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into the previously read word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merge_o
);

  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] rep;
  logic [3:0]      mask;

  // Pick the addressed byte/halfword and extend it to a full word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    load_o   = word_i;
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'h0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Replicate store data across lanes, then keep old bytes outside the mask.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   rep = {4{wdata_i[7:0]}};
      2'b01:   rep = {2{wdata_i[15:0]}};
      default: rep = wdata_i;
    endcase
    mask    = lane_mask(funct3_i, off_i);
    merge_o = word_i;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merge_o[8*i +: 8] = rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit controller: valid/ready request capture, fault check,
// load / word store / read-modify-write sub-word store sequencing.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault; when
// undefined, word accesses ignore addr[1:0] and halfwords ignore addr[0].
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int XLEN      = 32
) (
  input  logic         clk,
  input  logic         rst,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [XLEN-3:0] IDX_LIMIT = (XLEN-2)'(MEM_WORDS);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            mem_we_q, mem_we_d;

  logic            accept;
  logic            req_fault;
  logic            misalign;
  logic [XLEN-1:0] load_w;
  logic [XLEN-1:0] merge_w;

  lsu_align #(.XLEN(XLEN)) u_align (
    .word_i   (bus.mem_RD),
    .off_i    (addr_q[1:0]),
    .funct3_i (funct3_q),
    .wdata_i  (wdata_q),
    .load_o   (load_w),
    .merge_o  (merge_w)
  );

  // Legality, alignment and range check on the incoming request.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0]) ||
               ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_fault = misalign || (bus.req_addr[XLEN-1:2] >= IDX_LIMIT);
    if (bus.req_we) begin
      if (!(bus.req_funct3 inside {F3_B, F3_H, F3_W})) req_fault = 1'b1;
    end else begin
      if (bus.req_funct3 inside {3'b011, 3'b110, 3'b111}) req_fault = 1'b1;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
      wd_q     <= '0;
      mem_we_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      wd_q     <= wd_d;
      mem_we_q <= mem_we_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_fault)                      state_d = ST_RESP;
          else if (!bus.req_we)               state_d = ST_READ;
          else if (bus.req_funct3 == F3_W)    state_d = ST_WRITE;
          else                                state_d = ST_READ;
        end
      end
      ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture at acceptance, load data / merged word at the end of READ.
  always_comb begin
    accept   = (state_q == ST_IDLE) && bus.req_valid;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    wd_d     = wd_q;
    if (accept) begin
      addr_d   = bus.req_addr;
      funct3_d = bus.req_funct3;
      we_d     = bus.req_we;
      wdata_d  = bus.req_wdata;
      fault_d  = req_fault;
      rdata_d  = '0;
      if (bus.req_we && (bus.req_funct3 == F3_W) && !req_fault) wd_d = bus.req_wdata;
    end
    if (state_q == ST_READ) begin
      if (we_q) wd_d    = merge_w;
      else      rdata_d = load_w;
    end
    mem_we_d = (state_d == ST_WRITE);
  end

  // Outputs, driven from state and registers only.
  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.rsp_fault = (state_q == ST_RESP) && fault_q;
    bus.rsp_rdata = rdata_q;
    bus.mem_A     = {2'b00, addr_q[XLEN-1:2]};
    bus.mem_WD    = wd_q;
    bus.mem_WE    = mem_we_q;
  end

endmodule
